// File: rtl/stack_mem_stage_if.sv
// MEM-stage bundle between the EX/MEM register (master side) and the
// stack/memory unit (slave side), plus a debug view of the sequencer state.
interface stack_mem_stage_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3
);
  localparam int AW = $clog2(DEPTH);

  // Slot handshake: a slot with in_valid=1 is consumed on any edge where
  // stall=0; while stall=1 the producer must hold and nothing is consumed.
  logic              in_valid;
  logic              mem_read;
  logic              mem_write;
  logic              push;
  logic              pop;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        rdst_addr;
  logic              wb;
  logic              int_req;
  logic              rti;
  logic [PC_W-1:0]   pc;
  logic [FLAG_W-1:0] flags;

  logic              stall;
  logic              out_valid;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        rdst_out;
  logic              wb_out;
  logic              restore_valid;
  logic [PC_W-1:0]   pc_out;
  logic [FLAG_W-1:0] flags_out;
  logic [AW-1:0]     sp;
  logic              overflow;
  logic              underflow;
  logic [2:0]        dbg_state;

  modport master (
    output in_valid, mem_read, mem_write, push, pop, addr, wdata, alu_result,
           rdst_addr, wb, int_req, rti, pc, flags,
    input  stall, out_valid, rdata, alu_out, rdst_out, wb_out, restore_valid,
           pc_out, flags_out, sp, overflow, underflow, dbg_state
  );

  modport slave (
    input  in_valid, mem_read, mem_write, push, pop, addr, wdata, alu_result,
           rdst_addr, wb, int_req, rti, pc, flags,
    output stall, out_valid, rdata, alu_out, rdst_out, wb_out, restore_valid,
           pc_out, flags_out, sp, overflow, underflow, dbg_state
  );
endinterface

// File: rtl/stack_mem_stage.sv
// Memory stage: data memory, empty-descending hardware stack with occupancy
// tracking, and a sequencer for interrupt entry and return-from-interrupt.
module stack_mem_stage #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3
) (
  input logic              clk,
  input logic              rst,
  stack_mem_stage_if.slave bus
);
  localparam int AW       = $clog2(DEPTH);
  localparam int PC_WORDS = PC_W / DATA_W;
  localparam int KW       = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] SP_ONE   = AW'(1);
  localparam logic [AW-1:0] SP_RESET = AW'(DEPTH-1);
  localparam logic [KW-1:0] K_LAST   = KW'(PC_WORDS-1);
  localparam logic [KW-1:0] K_ONE    = KW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_INT_PC, S_INT_FLG, S_RTI_FLG, S_RTI_PC, S_RESTORE
  } state_t;

  state_t            r_state, w_state_next;
  logic [KW-1:0]     r_k, w_k_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PC_W-1:0]   r_pc_lat;
  logic [FLAG_W-1:0] r_flags_lat;
  logic [AW-1:0]     r_sp;
  logic [AW:0]       r_cnt;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_alu_out;
  logic [2:0]        r_rdst_out;
  logic              r_wb_out;
  logic [PC_W-1:0]   r_pc_out;
  logic [FLAG_W-1:0] r_flags_out;

  logic              w_idle, w_slot_go;
  logic              w_slot_push, w_slot_pop, w_slot_wr, w_slot_rd;
  logic              w_push, w_pop, w_full, w_empty, w_do_push, w_do_pop;
  logic [AW-1:0]     w_sp_inc;
  logic [DATA_W-1:0] w_pc_word, w_push_data, w_pop_data, w_slot_rdata;

  // Slot decode: push&pop cancel each other; write wins over read.
  assign w_idle      = (r_state == S_IDLE);
  assign w_slot_go   = bus.in_valid & w_idle;
  assign w_slot_push = w_slot_go & bus.push & ~bus.pop;
  assign w_slot_pop  = w_slot_go & bus.pop & ~bus.push;
  assign w_slot_wr   = w_slot_go & ~bus.push & ~bus.pop & bus.mem_write;
  assign w_slot_rd   = w_slot_go & ~bus.push & ~bus.pop & ~bus.mem_write & bus.mem_read;

  // Slot and sequencer stack ops are mutually exclusive (IDLE vs non-IDLE).
  assign w_push    = w_slot_push | (r_state == S_INT_PC) | (r_state == S_INT_FLG);
  assign w_pop     = w_slot_pop | (r_state == S_RTI_FLG) | (r_state == S_RTI_PC);
  assign w_full    = (r_cnt == CNT_FULL);
  assign w_empty   = (r_cnt == '0);
  assign w_do_push = w_push & ~w_full;
  assign w_do_pop  = w_pop & ~w_empty;
  assign w_sp_inc  = r_sp + SP_ONE;

  assign w_pop_data   = w_do_pop ? r_mem[w_sp_inc] : '0;
  assign w_slot_rdata = w_slot_pop ? w_pop_data :
                        (w_slot_rd ? r_mem[bus.addr] : '0);

  // Interrupt entry pushes the most significant PC word first.
  always_comb begin
    w_pc_word = '0;
    for (int i = 0; i < PC_WORDS; i++) begin
      if (KW'(PC_WORDS-1-i) == r_k) w_pc_word = r_pc_lat[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_push_data = bus.wdata;
    if (r_state == S_INT_PC)       w_push_data = w_pc_word;
    else if (r_state == S_INT_FLG) w_push_data = DATA_W'(r_flags_lat);
  end

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    case (r_state)
      S_IDLE: begin
        w_k_next = '0;
        if (bus.int_req)  w_state_next = S_INT_PC;
        else if (bus.rti) w_state_next = S_RTI_FLG;
      end
      S_INT_PC: begin
        w_k_next = r_k + K_ONE;
        if (r_k == K_LAST) w_state_next = S_INT_FLG;
      end
      S_INT_FLG: w_state_next = S_IDLE;
      S_RTI_FLG: begin
        w_k_next     = '0;
        w_state_next = S_RTI_PC;
      end
      S_RTI_PC: begin
        w_k_next = r_k + K_ONE;
        if (r_k == K_LAST) w_state_next = S_RESTORE;
      end
      S_RESTORE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
    end
  end

  // Memory contents survive reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_do_push)      r_mem[r_sp]     <= w_push_data;
      else if (w_slot_wr) r_mem[bus.addr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_lat    <= '0;
      r_flags_lat <= '0;
      r_sp        <= SP_RESET;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_out_valid <= 1'b0;
      r_rdata     <= '0;
      r_alu_out   <= '0;
      r_rdst_out  <= '0;
      r_wb_out    <= 1'b0;
      r_pc_out    <= '0;
      r_flags_out <= '0;
    end else begin
      if (w_do_push) begin
        r_sp  <= r_sp - SP_ONE;
        r_cnt <= r_cnt + CNT_ONE;
      end else if (w_do_pop) begin
        r_sp  <= w_sp_inc;
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (w_push && w_full)  r_overflow  <= 1'b1;
      if (w_pop && w_empty)  r_underflow <= 1'b1;

      r_out_valid <= w_slot_go;
      r_rdata     <= w_slot_go ? w_slot_rdata : '0;
      r_alu_out   <= w_slot_go ? bus.alu_result : '0;
      r_rdst_out  <= w_slot_go ? bus.rdst_addr : '0;
      r_wb_out    <= w_slot_go & bus.wb;

      if (w_idle && bus.int_req) begin
        r_pc_lat    <= bus.pc;
        r_flags_lat <= bus.flags;
      end
      if (r_state == S_RTI_FLG) r_flags_out <= w_pop_data[FLAG_W-1:0];
      // Return PC is rebuilt least significant word first.
      if (r_state == S_RTI_PC) begin
        for (int i = 0; i < PC_WORDS; i++) begin
          if (KW'(i) == r_k) r_pc_out[i*DATA_W +: DATA_W] <= w_pop_data;
        end
      end
    end
  end

  assign bus.stall         = ~w_idle;
  assign bus.restore_valid = (r_state == S_RESTORE);
  assign bus.out_valid     = r_out_valid;
  assign bus.rdata         = r_rdata;
  assign bus.alu_out       = r_alu_out;
  assign bus.rdst_out      = r_rdst_out;
  assign bus.wb_out        = r_wb_out;
  assign bus.pc_out        = r_pc_out;
  assign bus.flags_out     = r_flags_out;
  assign bus.sp            = r_sp;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
  assign bus.dbg_state     = r_state;
endmodule

// File: tb/tb_stack_mem_stage.sv
`timescale 1ns/1ps
// Bench for stack_mem_stage at DEPTH=16: reset checks, a vector table, hand
// sequences for interrupt entry / RTI / reset abort, then randomized traffic.
module tb_stack_mem_stage;
  localparam int DATA_W   = 16;
  localparam int DEPTH    = 16;
  localparam int PC_W     = 32;
  localparam int FLAG_W   = 3;
  localparam int AW       = $clog2(DEPTH);
  localparam int PC_WORDS = PC_W / DATA_W;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_mem_stage_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W), .FLAG_W(FLAG_W)) bus ();
  stack_mem_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] m_mem [DEPTH];
  int  m_cnt = 0;
  bit  m_ovf = 1'b0;
  bit  m_unf = 1'b0;
  bit  e_valid;
  logic [DATA_W-1:0] e_alu;
  logic [2:0]        e_rdst;
  bit  e_wb;

  // SP follows from occupancy: next free word below the last pushed one.
  function automatic int m_sp();
    return (DEPTH - 1 - m_cnt + DEPTH) % DEPTH;
  endfunction

  function automatic void m_push(input logic [DATA_W-1:0] d);
    if (m_cnt == DEPTH) m_ovf = 1'b1;
    else begin
      m_mem[m_sp()] = d;
      m_cnt++;
    end
  endfunction

  function automatic logic [DATA_W-1:0] m_pop();
    if (m_cnt == 0) begin
      m_unf = 1'b1;
      return '0;
    end
    m_cnt--;
    return m_mem[m_sp()];
  endfunction

  typedef struct {
    bit v, rd, wr, ps, pp;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wd, alu;
    logic [2:0]        rdst;
    bit wb;
    bit e_v;
    logic [DATA_W-1:0] e_rd;
    logic [AW-1:0]     e_sp;
    bit e_ovf, e_unf;
  } vec_t;
  vec_t tbl [14];

  logic [31:0] got_pc;
  logic [2:0]  got_fl;
  int sel;

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.alu_result = '0; bus.rdst_addr = '0; bus.wb = 1'b0;
    bus.int_req = 1'b0; bus.rti = 1'b0; bus.pc = '0; bus.flags = '0;
  endtask

  task automatic set_slot(input bit v, input bit rd, input bit wr, input bit ps, input bit pp,
                          input logic [AW-1:0] a, input logic [DATA_W-1:0] wd,
                          input logic [DATA_W-1:0] alu, input logic [2:0] rdst, input bit wb);
    bus.in_valid = v; bus.mem_read = rd; bus.mem_write = wr; bus.push = ps; bus.pop = pp;
    bus.addr = a; bus.wdata = wd; bus.alu_result = alu; bus.rdst_addr = rdst; bus.wb = wb;
  endtask

  task automatic drive_rand_slot();
    int op;
    op = $urandom_range(0, 6);
    bus.in_valid   = ($urandom_range(0, 4) != 0);
    bus.push       = (op == 0) || (op == 5) || (op == 6);
    bus.pop        = (op == 1) || (op == 5) || (op == 6);
    bus.mem_write  = (op == 2) || (op == 4) || (op == 6);
    bus.mem_read   = (op == 3) || (op == 4) || (op == 6);
    bus.addr       = AW'($urandom_range(0, DEPTH-1));
    bus.wdata      = DATA_W'($urandom);
    bus.alu_result = DATA_W'($urandom);
    bus.rdst_addr  = 3'($urandom_range(0, 7));
    bus.wb         = ($urandom_range(0, 1) == 1);
  endtask

  // Predicts the effect of the slot currently on the bus at the next edge.
  task automatic slot_model(input bit idle);
    logic [DATA_W-1:0] r;
    bit go;
    r  = '0;
    go = bus.in_valid && idle;
    if (go) begin
      if (bus.push && bus.pop)  r = '0;
      else if (bus.push)        m_push(bus.wdata);
      else if (bus.pop)         r = m_pop();
      else if (bus.mem_write)   m_mem[bus.addr] = bus.wdata;
      else if (bus.mem_read)    r = m_mem[bus.addr];
    end
    e_valid = go;
    e_alu   = bus.alu_result;
    e_rdst  = bus.rdst_addr;
    e_wb    = bus.wb;
    exp_q.push_back(r);
  endtask

  task automatic check_slot(input string tag);
    logic [DATA_W-1:0] r;
    r = exp_q.pop_front();
    chk({tag, ".out_valid"}, bus.out_valid, e_valid);
    if (e_valid) begin
      chk({tag, ".rdata"}, bus.rdata, r);
      chk({tag, ".alu_out"}, bus.alu_out, e_alu);
      chk({tag, ".rdst_out"}, bus.rdst_out, e_rdst);
      chk({tag, ".wb_out"}, bus.wb_out, e_wb);
    end
    chk({tag, ".sp"}, bus.sp, m_sp());
    chk({tag, ".overflow"}, bus.overflow, m_ovf);
    chk({tag, ".underflow"}, bus.underflow, m_unf);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".rdata"}, bus.rdata, 0);
    chk({tag, ".alu_out"}, bus.alu_out, 0);
    chk({tag, ".rdst_out"}, bus.rdst_out, 0);
    chk({tag, ".wb_out"}, bus.wb_out, 0);
    chk({tag, ".restore_valid"}, bus.restore_valid, 0);
    chk({tag, ".pc_out"}, bus.pc_out, 0);
    chk({tag, ".flags_out"}, bus.flags_out, 0);
    chk({tag, ".overflow"}, bus.overflow, 0);
    chk({tag, ".underflow"}, bus.underflow, 0);
    chk({tag, ".stall"}, bus.stall, 0);
    chk({tag, ".sp"}, bus.sp, DEPTH-1);
  endtask

  // Asynchronous reset: outputs are checked before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    clear_inputs();
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    exp_q.delete();
  endtask

  task automatic init_mem();
    for (int a = 0; a < DEPTH; a++) begin
      set_slot(T, F, T, F, F, AW'(a), DATA_W'($urandom), 16'h0, 3'd0, F);
      slot_model(1'b1);
      step();
      check_slot("init");
    end
  endtask

  // Slot for the request cycle must already be on the bus.
  task automatic run_int(input logic [31:0] pc, input logic [2:0] fl, input bit with_rti,
                         input bit rand_slots);
    bus.int_req = 1'b1; bus.rti = with_rti; bus.pc = pc; bus.flags = fl;
    slot_model(1'b1);
    step();
    check_slot("int.req");
    bus.int_req = 1'b0; bus.rti = 1'b0;
    for (int j = 0; j <= PC_WORDS; j++) begin
      if (rand_slots) drive_rand_slot(); else bus.in_valid = 1'b0;
      chk("int.stall", bus.stall, 1);
      slot_model(1'b0);
      if (j < PC_WORDS) m_push(pc[(PC_WORDS-1-j)*DATA_W +: DATA_W]);
      else              m_push(DATA_W'(fl));
      step();
      check_slot("int.push");
    end
    chk("int.stall_end", bus.stall, 0);
  endtask

  task automatic run_rti(input bit rand_slots, output logic [31:0] pc_seen,
                         output logic [2:0] fl_seen);
    logic [DATA_W-1:0] fl_w;
    logic [PC_W-1:0]   pc_m;
    fl_w = '0;
    pc_m = '0;
    bus.rti = 1'b1;
    slot_model(1'b1);
    step();
    check_slot("rti.req");
    bus.rti = 1'b0;
    for (int j = 0; j <= PC_WORDS; j++) begin
      if (rand_slots) drive_rand_slot(); else bus.in_valid = 1'b0;
      chk("rti.stall", bus.stall, 1);
      chk("rti.rv_early", bus.restore_valid, 0);
      slot_model(1'b0);
      if (j == 0) fl_w = m_pop();
      else        pc_m[(j-1)*DATA_W +: DATA_W] = m_pop();
      step();
      check_slot("rti.pop");
    end
    chk("rti.stall_restore", bus.stall, 1);
    chk("rti.restore_valid", bus.restore_valid, 1);
    chk("rti.pc_out", bus.pc_out, pc_m);
    chk("rti.flags_out", bus.flags_out, fl_w[FLAG_W-1:0]);
    pc_seen = bus.pc_out;
    fl_seen = bus.flags_out;
    slot_model(1'b0);
    step();
    check_slot("rti.end");
    chk("rti.stall_end", bus.stall, 0);
    chk("rti.rv_end", bus.restore_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;

    //            v  rd wr ps pp addr   wdata     alu       rdst  wb  e_v e_rdata   e_sp   ovf unf
    tbl[0]  = '{T, F, F, T, F, 4'd0,  16'hAAAA, 16'h0101, 3'd1, T,  T, 16'h0000, 4'd14, F, F};
    tbl[1]  = '{T, F, F, T, F, 4'd0,  16'h5555, 16'h0202, 3'd2, F,  T, 16'h0000, 4'd13, F, F};
    tbl[2]  = '{T, F, F, F, T, 4'd0,  16'h0000, 16'h0303, 3'd3, T,  T, 16'h5555, 4'd14, F, F};
    tbl[3]  = '{T, F, F, F, T, 4'd0,  16'h0000, 16'h0404, 3'd4, T,  T, 16'hAAAA, 4'd15, F, F};
    tbl[4]  = '{T, F, T, F, F, 4'd3,  16'h1234, 16'h0505, 3'd5, F,  T, 16'h0000, 4'd15, F, F};
    tbl[5]  = '{T, T, F, F, F, 4'd3,  16'h0000, 16'hBEEF, 3'd6, T,  T, 16'h1234, 4'd15, F, F};
    tbl[6]  = '{T, T, T, F, F, 4'd3,  16'h7777, 16'h0606, 3'd7, T,  T, 16'h0000, 4'd15, F, F};
    tbl[7]  = '{T, T, F, F, F, 4'd3,  16'h0000, 16'h0707, 3'd0, T,  T, 16'h7777, 4'd15, F, F};
    tbl[8]  = '{F, T, F, F, F, 4'd3,  16'h0000, 16'h0808, 3'd1, T,  F, 16'h0000, 4'd15, F, F};
    tbl[9]  = '{T, F, F, T, T, 4'd0,  16'h9999, 16'h0909, 3'd2, T,  T, 16'h0000, 4'd15, F, F};
    tbl[10] = '{T, T, F, F, F, 4'd15, 16'h0000, 16'h0A0A, 3'd3, F,  T, 16'hAAAA, 4'd15, F, F};
    tbl[11] = '{T, F, F, F, T, 4'd0,  16'h0000, 16'h0B0B, 3'd4, F,  T, 16'h0000, 4'd15, F, T};
    tbl[12] = '{T, F, F, T, F, 4'd0,  16'h0BAD, 16'h0C0C, 3'd5, T,  T, 16'h0000, 4'd14, F, T};
    tbl[13] = '{T, F, F, F, T, 4'd0,  16'h0000, 16'h0D0D, 3'd6, T,  T, 16'h0BAD, 4'd15, F, T};

    for (int i = 0; i < 14; i++) begin
      set_slot(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].ps, tbl[i].pp, tbl[i].addr,
               tbl[i].wd, tbl[i].alu, tbl[i].rdst, tbl[i].wb);
      step();
      chk($sformatf("vec%0d.out_valid", i), bus.out_valid, tbl[i].e_v);
      if (tbl[i].e_v) begin
        chk($sformatf("vec%0d.rdata", i), bus.rdata, tbl[i].e_rd);
        chk($sformatf("vec%0d.alu_out", i), bus.alu_out, tbl[i].alu);
        chk($sformatf("vec%0d.rdst_out", i), bus.rdst_out, tbl[i].rdst);
        chk($sformatf("vec%0d.wb_out", i), bus.wb_out, tbl[i].wb);
      end
      chk($sformatf("vec%0d.sp", i), bus.sp, tbl[i].e_sp);
      chk($sformatf("vec%0d.overflow", i), bus.overflow, tbl[i].e_ovf);
      chk($sformatf("vec%0d.underflow", i), bus.underflow, tbl[i].e_unf);
    end

    // Overflow: the 17th push is suppressed.
    do_reset("rst1");
    init_mem();
    for (int i = 0; i < 17; i++) begin
      set_slot(T, F, F, T, F, 4'd0, 16'(16'h1000 + i), 16'h0, 3'd0, F);
      slot_model(1'b1);
      step();
      check_slot("ovf.push");
      if (i == 15) begin
        chk("full.sp", bus.sp, 15);
        chk("full.overflow", bus.overflow, 0);
      end
    end
    chk("ovf.flag", bus.overflow, 1);
    chk("ovf.sp", bus.sp, 15);
    for (int i = 0; i < 16; i++) begin
      set_slot(T, F, F, F, T, 4'd0, 16'h0, 16'h0, 3'd0, F);
      slot_model(1'b1);
      step();
      check_slot("drain.pop");
      chk("drain.value", bus.rdata, 16'h100F - 16'(i));
    end
    set_slot(T, F, F, F, T, 4'd0, 16'h0, 16'h0, 3'd0, F);
    slot_model(1'b1);
    step();
    check_slot("unf.pop");
    chk("unf.flag", bus.underflow, 1);
    chk("unf.rdata", bus.rdata, 0);

    // Interrupt entry followed by RTI.
    do_reset("rst2");
    run_int(32'h0001_0042, 3'b101, 1'b0, 1'b0);
    chk("int.sp", bus.sp, 12);
    for (int i = 0; i < 3; i++) begin
      set_slot(T, T, F, F, F, AW'(15 - i), 16'h0, 16'h0, 3'd0, F);
      slot_model(1'b1);
      step();
      check_slot("int.load");
      chk($sformatf("int.mem%0d", 15 - i), bus.rdata,
          (i == 0) ? 16'h0001 : ((i == 1) ? 16'h0042 : 16'h0005));
    end
    bus.in_valid = 1'b0;
    run_rti(1'b0, got_pc, got_fl);
    chk("rti.pc_value", got_pc, 32'h0001_0042);
    chk("rti.flags_value", got_fl, 3'b101);
    chk("rti.sp", bus.sp, 15);

    // int_req and rti together: entry wins.
    run_int(32'hCAFE_F00D, 3'b011, 1'b1, 1'b0);
    chk("both.sp", bus.sp, 12);
    run_rti(1'b0, got_pc, got_fl);
    chk("both.pc_value", got_pc, 32'hCAFE_F00D);
    chk("both.flags_value", got_fl, 3'b011);

    // Reset during INT_PC aborts the sequence.
    do_reset("rst3");
    bus.int_req = 1'b1; bus.pc = 32'h0001_0042; bus.flags = 3'b101;
    slot_model(1'b1);
    step();
    check_slot("abort.req");
    bus.int_req = 1'b0;
    chk("abort.stall", bus.stall, 1);
    slot_model(1'b0);
    m_push(16'h0001);
    step();
    check_slot("abort.pc0");
    do_reset("abort.rst");
    for (int j = 0; j < 6; j++) begin
      chk("abort.restore_valid", bus.restore_valid, 0);
      chk("abort.stall", bus.stall, 0);
      step();
    end

    // Randomized traffic against the model.
    do_reset("rst4");
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 39);
      drive_rand_slot();
      if (sel == 0)      run_int($urandom, 3'($urandom_range(0, 7)), 1'b0, 1'b1);
      else if (sel == 1) run_int($urandom, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
      else if (sel < 4)  run_rti(1'b1, got_pc, got_fl);
      else begin
        slot_model(1'b1);
        step();
        check_slot("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_mem_stage.md
# stack_mem_stage

Parametrised memory-stage unit: it owns the data memory and a hardware stack pointer and registers results into the MEM/WB boundary. Beyond plain load/store and push/pop, it sequences multi-word interrupt entry (push PC words and flags) and RTI exit (pop and restore) on its own, stalling upstream while it runs. It also tracks stack occupancy and flags overflow and underflow. It sits between the EX/MEM and MEM/WB pipeline registers.

## Interface
- DATA_W, 16, memory word and register width
- DEPTH, 1024, memory words (power of 2); AW = clog2(DEPTH)
- PC_W, 32, PC width; must be a multiple of DATA_W; PC_WORDS = PC_W/DATA_W
- FLAG_W, 3, CCR width (≤ DATA_W)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MEM slot holds a valid instruction
- mem_read, mem_write  in  1  load / store
- push, pop  in  1  stack op with data from wdata / into rdata
- addr  in  AW  load/store address
- wdata  in  DATA_W  store/push data
- alu_result  in  DATA_W  passed through to WB
- rdst_addr  in  3  destination register; wb  in  1  write-back enable
- int_req  in  1  single-cycle interrupt entry request
- rti  in  1  single-cycle return-from-interrupt request
- pc  in  PC_W  return PC; flags  in  FLAG_W  CCR to save
- stall  out  1  upstream must hold; high in any non-IDLE state
- out_valid  out  1  MEM/WB slot valid
- rdata, alu_out  out  DATA_W  loaded/popped data, passed ALU result
- rdst_out  out  3; wb_out  out  1
- restore_valid  out  1  one-cycle pulse: pc_out/flags_out valid
- pc_out  out  PC_W; flags_out  out  FLAG_W
- sp  out  AW  current stack pointer
- overflow, underflow  out  1  sticky error flags

## Operation
- Stack is empty-descending: SP points to the next free word. Push writes mem[SP] and then decrements SP. Pop reads mem[SP+1] and then increments SP. All SP arithmetic is modulo DEPTH.
- Internal cnt (AW+1 bits) holds stack occupancy. Stack is full when cnt==DEPTH and empty when cnt==0.
- A push while full is suppressed: no write, SP and cnt unchanged, overflow←1.
- A pop while empty is suppressed: rdata=0, SP and cnt unchanged, underflow←1.
- overflow and underflow clear only on rst.
- Per-slot priority (only when in_valid & !stall):
  - push&pop together: no memory access, no SP change.
  - Otherwise push, then pop, then mem_write, then mem_read.
  - mem_write&mem_read together: the write occurs and rdata=0.
- Writes are synchronous. Reads are combinational from the array and captured into rdata on the edge.
- FSM states: IDLE, INT_PC, INT_FLG, RTI_FLG, RTI_PC, RESTORE.
- IDLE:
  - int_req → INT_PC, latching pc/flags and setting k=0.
  - Else rti → RTI_FLG.
  - int_req beats rti when both are high.
  - A valid slot presented in the same cycle still executes; the FSM acts from the next cycle.
- INT_PC: each cycle push PC word PC_WORDS-1-k (MS word first), k++. After the last word → INT_FLG.
- INT_FLG: push the zero-extended flags → IDLE.
- RTI_FLG: pop into flags_out, k=0 → RTI_PC.
- RTI_PC: each cycle pop into PC word k (LS word first). After the last word → RESTORE.
- RESTORE: restore_valid=1 for one cycle → IDLE.
- FSM pushes and pops obey the same full/empty suppression rules. A suppressed pop contributes 0 to pc_out/flags_out.
- out_valid is 0 for FSM cycles.

## Timing
- Reset values:
  - sp=DEPTH-1, cnt=0, state=IDLE.
  - All outputs 0, including overflow and underflow.
  - Memory contents are not reset.
- rst mid-sequence aborts the sequence: no restore_valid, SP returns to DEPTH-1.
- Slot latency 1 cycle. Inputs accepted at edge N appear on out_valid, rdata, alu_out, rdst_out and wb_out after edge N. out_valid=0 when in_valid=0 or stall=1.
- stall is combinational from state (stall = state≠IDLE).
- Interrupt entry duration: PC_WORDS+1 cycles, then IDLE.
- RTI duration: 1+PC_WORDS+1 cycles. restore_valid is high in the final cycle.
- sp output updates on the same edge as the corresponding write/read.

## Test plan
- Defaults with DEPTH=16. Push 0xAAAA, push 0x5555, pop, pop → sp 15→14→13→14→15; rdata 0x5555 then 0xAAAA one cycle after each pop.
- Store 0x1234 @addr 3, then load @3 → rdata=0x1234 next cycle, out_valid=1, wb_out and rdst_out passed through.
- Pop on empty → underflow=1, rdata=0, sp stays 15. Push 17 times → 17th suppressed, overflow=1, sp stays 15, cnt=16.
- int_req with pc=0x0001_0042, flags=3'b101 → stall high 3 cycles; mem[15]=0x0001, mem[14]=0x0042, mem[13]=0x0005; sp=12.
- Then rti → stall 4 cycles; restore_valid pulse with pc_out=0x0001_0042, flags_out=3'b101; sp=15.
- int_req and rti asserted together in IDLE → interrupt entry runs. Assert rst during INT_PC → all outputs 0, sp=15, no restore_valid afterwards.
